// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiply / restoring divide into HI/LO (clk, reset, start/op/a_in/b_in in; hi_out/lo_out/busy/done/div_zero out; MULTDIV_DIVZERO_EXC_EN enables the divide-by-zero fast exit)
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
`ifdef MULTDIV_DIVZERO_EXC_EN
  localparam bit DZ_EXC = 1'b1;
`else
  localparam bit DZ_EXC = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc, mul_nx, div_nx;
  logic [WIDTH-1:0] opnd, a_reg, abs_a, abs_b, quo, rem, res_hi, res_lo;
  logic [WIDTH:0] p_ext, m_ext, sum, rem_sh, trial;
  logic sa, sb, dz, last, run;
  assign abs_a = a_in[WIDTH-1] ? -a_in : a_in;
  assign abs_b = b_in[WIDTH-1] ? -b_in : b_in;
  assign last = cnt == CNT_W'(WIDTH);
  assign run = state == MULT || state == DIV;
  always_comb begin
    p_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_ext = {opnd[WIDTH-1], opnd};
    sum = acc[1:0] == 2'b01 ? p_ext + m_ext : acc[1:0] == 2'b10 ? p_ext - m_ext : p_ext;
    mul_nx = {sum, acc[WIDTH:1]};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    trial = rem_sh - {1'b0, opnd};
    div_nx = trial[WIDTH] ? {rem_sh, acc[WIDTH-2:0], 1'b0} : {trial, acc[WIDTH-2:0], 1'b1};
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    res_hi = state == MULT ? acc[2*WIDTH:WIDTH+1] : dz ? a_reg : sa ? -rem : rem;
    res_lo = state == MULT ? acc[WIDTH:1] : dz ? '1 : (sa ^ sb) ? -quo : quo;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? (op ? ((DZ_EXC && b_in == '0) ? FIN : DIV) : MULT) : IDLE) :
               state == FIN ? IDLE : last ? FIN : state;
    busy = state != IDLE;
    done = state == FIN;
    div_zero = DZ_EXC && done && dz;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      opnd <= '0;
      a_reg <= '0;
      cnt <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == IDLE && start) begin
      acc <= op ? {{(WIDTH+1){1'b0}}, abs_a} : {{WIDTH{1'b0}}, b_in, 1'b0};
      opnd <= op ? abs_b : a_in;
      a_reg <= a_in;
      cnt <= '0;
      sa <= a_in[WIDTH-1];
      sb <= b_in[WIDTH-1];
      dz <= op && b_in == '0;
    end else if (run && last) begin
      hi_out <= res_hi;
      lo_out <= res_lo;
    end else if (run) begin
      acc <= state == DIV ? div_nx : mul_nx;
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0, hi_out, lo_out;
  logic busy, done, div_zero;
  int checks = 0, errors = 0, cyc = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0, mh, ml;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic dz;
    int lat;
    int t0;
  } exp_t;
  exp_t q[$];
  exp_t e;
  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else begin
        e = q.pop_front();
        check("hi", hi_out, e.hi);
        check("lo", lo_out, e.lo);
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
        check("busy_fin", 32'(busy), 32'd1);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end else if (div_zero === 1'b1) check("stray_div_zero", 32'(div_zero), 32'd0);
  end
  task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    longint x, y;
    logic [63:0] r, s;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (!o) begin
      r = x * y;
      eh = r[63:32];
      el = r[31:0];
    end else begin
      r = x / y;
      s = x % y;
      eh = s[31:0];
      el = r[31:0];
    end
  endtask
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int lat);
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    q.push_back('{hi: eh, lo: el, dz: ed, lat: lat, t0: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    check("busy_rise", 32'(busy), 32'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
    if (done !== 1'b1) begin
      check("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic o;
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_hi", hi_out, '0);
    check("rst_lo", lo_out, '0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33); drain();
    issue(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33); drain();
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33); drain();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33); drain();
`ifdef MULTDIV_DIVZERO_EXC_EN
    issue(1'b1, 32'd5, 32'd0, 32'h0, 32'h80000000, 1'b1, 1); drain();
`else
    issue(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 33); drain();
`endif
    issue(1'b1, 32'd0, 32'h1234, 32'h0, 32'h0, 1'b0, 33); drain();
    for (int i = 0; i < 8; i++) begin
      o = 1'(i);
      a = (i % 3 == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      b = (i % 4 == 1) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      if (o && b == '0) b = 32'd3;
      model(o, a, b, mh, ml);
      issue(o, a, b, mh, ml, 1'b0, 33);
      drain();
    end
    issue(1'b0, 32'd123, -32'd456, 32'hFFFFFFFF, -32'd56088, 1'b0, 33);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    a_in = 32'd9;
    b_in = 32'd3;
    check("hold_hi", hi_out, last_hi);
    check("hold_lo", lo_out, last_lo);
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom;
    drain();
    repeat (40) @(negedge clk);
    start = 1'b1;
    op = 1'b0;
    a_in = 32'd1000;
    b_in = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi_out, '0);
    check("abort_lo", lo_out, '0);
    check("abort_done", 32'(done), 32'd0);
    repeat (45) @(negedge clk);
    issue(1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33); drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit with HI/LO result registers for the MIPS-subset multicycle CPU.
- Sits downstream of the A/B operand registers and is driven by the control unit (mult/div opcodes).
- Its HI/LO outputs feed the write-data mux (mfhi/mflo paths).
- Uses a start/done handshake so the control FSM stalls in a wait state until completion.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  1  0 = signed multiply (mult), 1 = signed divide (div).
- a_in  input  WIDTH  multiplicand / dividend (from A register).
- b_in  input  WIDTH  multiplier / divisor (from B register).
- hi_out  output  WIDTH  HI register: product[2W-1:W], or remainder.
- lo_out  output  WIDTH  LO register: product[W-1:0], or quotient.
- busy  output  1  high while an operation is in flight (MULT/DIV/FIN).
- done  output  1  one-cycle pulse; HI/LO are valid in the same cycle.
- div_zero  output  1  one-cycle pulse with done when the divisor is 0 (see Optional Feature).

Behaviour:
- Reset (synchronous; takes priority over everything, including mid-operation):
  - state = IDLE; hi_out = lo_out = 0; busy = done = div_zero = 0; counter = 0.
  - An operation in flight is abandoned and produces no done.
- FSM states: IDLE, MULT, DIV, FIN.
- IDLE:
  - start = 1 at edge t0 latches a_in, b_in and op.
  - Goes to MULT (op = 0) or DIV (op = 1); counter = 0; busy rises after t0.
- MULT: radix-2 Booth iteration.
  - Holds the 2W+1-bit accumulator {P_hi, P_lo, q-1}.
  - Each cycle: add/subtract the multiplicand into P_hi per {q0, q-1}, then arithmetic-shift right by 1.
  - After exactly WIDTH iterations (edges t1..tWIDTH), go to FIN.
- DIV: restoring division on magnitudes.
  - Operands are converted to absolute values at entry.
  - Each cycle: shift remainder:quotient left 1, trial-subtract |b|, restore if negative, set the quotient bit.
  - WIDTH iterations, then FIN.
  - Sign fix-up in FIN:
    - quotient negated iff sign(a) != sign(b) (truncation toward zero);
    - remainder takes the sign of a.
- FIN (edge tWIDTH+1):
  - hi_out/lo_out load the results; done = 1 and busy = 1 for this single cycle.
  - Next edge returns to IDLE with done = 0 and busy = 0.
  - start is ignored in FIN.
- Latency:
  - done is high in the cycle after edge t0 + WIDTH + 1, i.e. 33 cycles after accept for WIDTH = 32.
  - The next start is accepted one cycle after the done pulse.
- Ignored start: start while busy is ignored; the latched operands are unaffected by later changes on a_in/b_in.
- Result retention: HI/LO hold their value until the next completed operation or reset; they are never cleared by start.
- Multiply: full 2W-bit signed product, no overflow.
  - -2^(W-1) * -2^(W-1) yields HI = 0x40000000, LO = 0.
- Divide -2^(W-1) / -1: LO = 0x80000000 (wraps), HI = 0, no flag.
- Divide with a_in = 0: LO = 0, HI = 0.

Optional Feature:
- Macro: MULTDIV_DIVZERO_EXC_EN.
- Defined:
  - div with b_in == 0 skips DIV and goes IDLE -> FIN directly.
  - done and div_zero pulse together one cycle after accept.
  - HI/LO stay unchanged.
  - The control unit uses div_zero to raise the divide-by-zero exception.
- Not defined:
  - div_zero is tied to 0.
  - Divide-by-zero takes the normal WIDTH + 1 latency and writes HI = a_in, LO = all ones (forced, not algorithm output).

Test Plan:
- Reset, then mult a = 7, b = 0xFFFFFFFD (-3) -> busy for 33 cycles; done pulse with HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- mult 0x80000000 * 0x80000000 -> HI = 0x40000000, LO = 0x00000000.
- div a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
- Then div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- div by 0 with a = 5:
  - macro defined -> done and div_zero one cycle after accept, HI/LO unchanged;
  - macro undefined -> done after 33 cycles, HI = 5, LO = 0xFFFFFFFF, div_zero = 0.
- Start a mult and pulse start again at cycle 10 with new operands -> second start ignored; first result correct.
- Assert reset at cycle 15 -> next cycle busy = 0, HI = LO = 0, and no done pulse ever appears.
